// File: rtl/multicycle_control.sv
`timescale 1ns/1ps
// multicycle_control
//   Moore control FSM for a multicycle MIPS-style datapath. The FSM walks
//   each instruction through its multicycle sequence. Datapath selects and
//   write enables decode from the current state only. The one exception is
//   PCEn, which also looks at the ALU zero flag so that a taken beq can
//   load the PC.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, forces FETCH immediately
//   op         opcode from the instruction register (used in DECODE/MEMADR)
//   zero       ALU zero flag (used only for PCEn in BRANCH)
//   IorD       memory address select: 0 = PC, 1 = ALUOut
//   IRWrite    instruction register load
//   MemWrite   memory write enable
//   RegWrite   register file write enable
//   RegDst     write register select: 0 = rt, 1 = rd
//   MemtoReg   write data select: 0 = ALUOut, 1 = memory data
//   ALUSrcA    ALU A select: 0 = PC, 1 = register A
//   ALUSrcB    ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm<<2
//   ALUOp      ALU class: 00 = add, 01 = subtract, 10 = funct field
//   PCSrc      next-PC select: 00 = ALUResult, 01 = ALUOut, 1x = jump target
//   PCEn       PC load enable
//   state      current state encoding (debug)
module multicycle_control #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  output logic            IorD,
  output logic            IRWrite,
  output logic            MemWrite,
  output logic            RegWrite,
  output logic            RegDst,
  output logic            MemtoReg,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSrc,
  output logic            PCEn,
  output logic [3:0]      state
);

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_RTYP = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  logic pc_write;
  logic branch;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic: op is only consulted in DECODE and MEMADR
  always_comb begin
    nxt_state = S_FETCH;
    case (cur_state)
      S_FETCH:  nxt_state = S_DECODE;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) begin
          nxt_state = S_MEMADR;
        end else if (op == OP_RTYP) begin
          nxt_state = S_EXEC;
        end else if (op == OP_BEQ) begin
          nxt_state = S_BRANCH;
        end else if (op == OP_ADDI) begin
          nxt_state = S_ADDIEX;
        end else if (op == OP_J) begin
          nxt_state = S_JUMP;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_MEMADR: begin
        // An opcode that is neither lw nor sw here abandons the instruction.
        if (op == OP_LW) begin
          nxt_state = S_MEMRD;
        end else if (op == OP_SW) begin
          nxt_state = S_MEMWR;
        end else begin
          nxt_state = S_FETCH;
        end
      end
      S_MEMRD:  nxt_state = S_MEMWB;
      S_EXEC:   nxt_state = S_ALUWB;
      S_ADDIEX: nxt_state = S_ADDIWB;
      S_MEMWB,
      S_MEMWR,
      S_ALUWB,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP:   nxt_state = S_FETCH;
      // Unused encodings 12-15 recover to FETCH.
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Moore output decode
  always_comb begin
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (cur_state)
      S_FETCH: begin
        IRWrite  = 1'b1;
        pc_write = 1'b1;
        ALUSrcB  = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
      end
      S_MEMADR,
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        PCSrc   = 2'b01;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSrc    = 2'b10;
      end
      default: begin
        // all outputs stay at their zero defaults
      end
    endcase
  end

  // A taken beq is the only path by which zero reaches the PC enable.
  assign PCEn  = pc_write | (branch & zero);
  assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
`timescale 1ns/1ps
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn;
  logic [3:0] state;

  multicycle_control #(.OP_W(6)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn),
    .state(state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {state, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
  //  ALUSrcB, ALUOp, PCSrc, PCEn}
  logic [17:0] act;
  assign act = {state, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg,
                ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn};

  logic [17:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got state=%0d ctl=%b required state=%0d ctl=%b",
               name, got[17:14], got[13:0], want[17:14], want[13:0]);
    end
  endtask

  // Reference control word for a state, taken from the per-state table.
  function automatic logic [17:0] exp_vec(input int st, input logic z);
    logic io, irw, mw, rw, rd, m2r, asa, pcw, br;
    logic [1:0] asb, aop, pcs;
    {io, irw, mw, rw, rd, m2r, asa, pcw, br} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin irw = 1; pcw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; br = 1; pcs = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {4'(st), io, irw, mw, rw, rd, m2r, asa, asb, aop, pcs, pcw | (br & z)};
  endfunction

  // Instruction-level model: the state path each opcode class walks.
  task automatic build_path(input logic [5:0] opc, output int path[$]);
    path = {0, 1};
    case (opc)
      6'b100011: path = {0, 1, 2, 3, 4};
      6'b101011: path = {0, 1, 2, 5};
      6'b000000: path = {0, 1, 6, 7};
      6'b000100: path = {0, 1, 8};
      6'b001000: path = {0, 1, 9, 10};
      6'b000010: path = {0, 1, 11};
      default:   path = {0, 1};
    endcase
  endtask

  // Drive one instruction cycle by cycle; op carries the opcode only where
  // the FSM samples it and is random noise elsewhere.
  // zmode: 0/1 fixed zero, 2 random. max_len limits cycles (0 = whole path).
  task automatic run_instr(input logic [5:0] opc, input int zmode,
                           input bit skip_fetch, input int max_len);
    int path[$];
    int n;
    build_path(opc, path);
    if (skip_fetch) void'(path.pop_front());
    n = (max_len > 0 && max_len < path.size()) ? max_len : path.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      op   = (path[i] == 1 || path[i] == 2) ? opc : 6'($urandom);
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      exp_q.push_back(exp_vec(path[i], zero));
    end
  endtask

  function automatic logic [5:0] rand_undef();
    logic [5:0] v;
    do v = 6'($urandom);
    while (v inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
    return v;
  endfunction

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 6))
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      default: return rand_undef();
    endcase
  endfunction

  // Reset pulsed between edges after the current cycle; returns with the
  // DUT in FETCH and reset released so the next posedge moves to DECODE.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check({tag, "_async"}, act, exp_vec(0, zero));
    @(posedge clk);
    #1;
    zero = 1'($urandom);
    exp_q.push_back(exp_vec(0, zero));
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check({tag, "_release"}, act, exp_vec(0, zero));
  endtask

  // Monitor: compares the DUT against the scoreboard on every falling edge.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("cycle_in_state%0d", e[17:14]), act, e);
      end
    end
  end

  // Stimulus
  initial begin
    int wait_cnt;
    reset = 1'b1;
    op    = 6'b100011;
    zero  = 1'b0;
    #3;
    check("reset_hold_z0", act, exp_vec(0, 1'b0));
    zero = 1'b1;
    #1;
    check("reset_hold_z1", act, exp_vec(0, 1'b1));
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Directed classes: lw, sw, beq taken/not taken, j, undefined, R, addi
    run_instr(6'b100011, 2, 1'b1, 0);
    run_instr(6'b101011, 2, 1'b0, 0);
    run_instr(6'b000100, 1, 1'b0, 0);
    run_instr(6'b000100, 0, 1'b0, 0);
    run_instr(6'b000010, 0, 1'b0, 0);
    run_instr(6'b111111, 2, 1'b0, 0);
    run_instr(6'b000000, 2, 1'b0, 0);
    run_instr(6'b001000, 2, 1'b0, 0);

    // lw interrupted in MEMRD, then a normal lw resumes from FETCH
    run_instr(6'b100011, 2, 1'b0, 4);
    pulse_reset("rst_memrd");
    run_instr(6'b100011, 2, 1'b1, 0);
    run_instr(6'b101011, 2, 1'b0, 0);

    // Random instruction stream with occasional mid-instruction resets
    for (int k = 0; k < 300; k++) begin
      logic [5:0] o;
      o = rand_op();
      if ($urandom_range(0, 19) == 0) begin
        run_instr(o, 2, 1'b0, $urandom_range(1, 4));
        pulse_reset("rst_rand");
        run_instr(rand_op(), 2, 1'b1, 0);
      end else begin
        run_instr(o, 2, 1'b0, 0);
      end
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      #1;
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter OP_W, default 6, meaning the opcode input width.
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 SHALL have port op, input, OP_W, the instruction opcode from the instruction register.
REQ-005 SHALL have port zero, input, 1, the ALU zero flag.
REQ-006 SHALL have ports IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, outputs, 1 each, the datapath selects and write enables.
REQ-007 SHALL have ports ALUSrcB and ALUOp, outputs, 2 each, the ALU operand-B select and the ALU operation class.
REQ-008 SHALL have port PCSrc, output, 2, the next-PC 3:1 mux select: 00 selects ALUResult, 01 selects ALUOut, 1x selects the jump target.
REQ-009 SHALL have port PCEn, output, 1, the PC register load enable.
REQ-010 SHALL have port state, output, 4, the current state encoding, for debug.

Function
REQ-011 SHALL implement a Moore FSM on a 4-bit state register; all outputs except PCEn SHALL decode from state only.
REQ-012 SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-013 SHALL take these transitions:
- FETCH->DECODE.
- DECODE on op 100011 (lw) or 101011 (sw) ->MEMADR.
- DECODE on op 000000 (R-type) ->EXEC.
- DECODE on op 000100 (beq) ->BRANCH.
- DECODE on op 001000 (addi) ->ADDIEX.
- DECODE on op 000010 (j) ->JUMP.
- DECODE on any other op ->FETCH.
REQ-014 SHALL take these further transitions:
- MEMADR on lw ->MEMRD; MEMADR on sw ->MEMWR.
- MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP ->FETCH.
REQ-015 SHALL sample op in DECODE and in MEMADR only.
REQ-016 SHALL drive each output to 0 in any state where this document does not assert it.
REQ-017 SHALL assert, per state:
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, PCSrc=00, IorD=0.
- DECODE: ALUSrcB=11.
- MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10.
- MEMRD: IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
- MEMWR: IorD=1, MemWrite=1.
REQ-018 SHALL assert, per state:
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
- ADDIWB: RegWrite=1, RegDst=0.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01.
- JUMP: PCWrite=1, PCSrc=10.
REQ-019 SHALL drive ALUOp=00 in every state other than EXEC and BRANCH.
REQ-020 SHALL compute PCEn = PCWrite | (Branch & zero) combinationally, with PCWrite and Branch as internal decoded signals.
REQ-021 SHALL force PCEn to 0 in BRANCH when zero=0, and SHALL leave PCEn independent of zero in every other state.
REQ-022 SHALL give each instruction class this latency from FETCH to its return to FETCH, inclusive: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; an undefined opcode 2 cycles.
REQ-023 SHALL map any state encoding 12-15 to FETCH on the next clock and drive all-zero outputs while in it.

Reset
REQ-024 SHALL, while reset=1, force state to FETCH immediately, without waiting for clk.
REQ-025 SHALL, while reset=1, drive the outputs to the FETCH values, giving PCEn=1.
REQ-026 SHALL, on reset asserted mid-instruction (e.g. in MEMRD), abandon the instruction, issue no RegWrite or MemWrite, and resume in FETCH on the first clock after reset deasserts.
REQ-027 SHALL advance FETCH->DECODE on the first rising edge of clk after reset deasserts.

Verification
REQ-028 SHALL pass lw: op=100011 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-029 SHALL pass sw: op=101011 -> states 0,1,2,5,0; MemWrite=1 with IorD=1 only in cycle 4; RegWrite stays 0.
REQ-030 SHALL pass beq: op=000100 -> with zero=1, PCEn=1 and PCSrc=01 in BRANCH; with zero=0, PCEn=0 in BRANCH.
REQ-031 SHALL pass j then an undefined opcode: op=000010 -> JUMP has PCSrc=10 and PCEn=1; op=111111 -> states 0,1,0.
REQ-032 SHALL pass R-type and addi: op=000000 -> EXEC has ALUOp=10, ALUWB has RegDst=1; op=001000 -> ADDIEX has ALUSrcB=10, ADDIWB has RegDst=0.
REQ-033 SHALL pass asynchronous reset: reset pulsed between clk edges while in MEMRD -> state=0 before the next edge; no write enables asserted; normal sequence resumes after release.
